// File: rtl/bira_fault_cam.sv
// Fault-collection CAM for BIRA: classifies BIST faults into pivots/non-pivots and tracks must-repair flags.
// Optional build macro BIRA_DUP_FILTER_EN discards faults that exactly match any stored entry.
module bira_fault_cam #(
  parameter int ROW_W   = 10,
  parameter int COL_W   = 10,
  parameter int BANK_W  = 2,
  parameter int PCAM    = 8,
  parameter int NPCAM   = 30,
  parameter int R_SPARE = 4,
  parameter int C_SPARE = 4,
  localparam int PW = $clog2(PCAM),
  localparam int CW = $clog2(NPCAM + 1),
  localparam int E  = 1 + BANK_W + ROW_W + COL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fault_valid,
  output logic                      fault_ready,
  input  logic [ROW_W-1:0]          row_addr,
  input  logic [COL_W-1:0]          col_addr,
  input  logic [BANK_W-1:0]         bank_addr,
  input  logic                      test_end,
  input  logic                      ana_ack,
  output logic [PCAM*(E+2)-1:0]     pivot_entries,
  output logic [NPCAM*(E+PW)-1:0]   npivot_entries,
  output logic [PW:0]               pivot_cnt,
  output logic [CW-1:0]             npivot_cnt,
  output logic                      early_term,
  output logic                      cam_done
);

  typedef enum logic [1:0] {S_COLLECT = 2'd0, S_TERM = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_p_valid [PCAM];
  logic [BANK_W-1:0]   r_p_bank  [PCAM];
  logic [ROW_W-1:0]    r_p_row   [PCAM];
  logic [COL_W-1:0]    r_p_col   [PCAM];
  logic                r_p_mr    [PCAM];
  logic                r_p_mc    [PCAM];
  logic [CW-1:0]       r_p_rcnt  [PCAM];
  logic [CW-1:0]       r_p_ccnt  [PCAM];
  logic                r_n_valid [NPCAM];
  logic [BANK_W-1:0]   r_n_bank  [NPCAM];
  logic [ROW_W-1:0]    r_n_row   [NPCAM];
  logic [COL_W-1:0]    r_n_col   [NPCAM];
  logic [PW-1:0]       r_n_ptr   [NPCAM];
  logic [PW:0]         r_pivot_cnt;
  logic [CW-1:0]       r_npivot_cnt;
  logic                r_early_term;

  logic                w_row_hit, w_col_hit, w_dup;
  logic [PW-1:0]       w_row_idx, w_col_idx;
  logic [CW-1:0]       w_rcnt_nxt, w_ccnt_nxt;
  logic                w_set_mr, w_set_mc;
  logic                w_accept, w_is_pivot, w_overflow, w_wr_p, w_wr_n, w_clear;

  // Pivots are unique per bank in row and column, so at most one hit of each kind.
  always_comb begin
    w_row_hit = 1'b0;
    w_col_hit = 1'b0;
    w_row_idx = '0;
    w_col_idx = '0;
    for (int i = 0; i < PCAM; i++) begin
      if (r_p_valid[i] && r_p_bank[i] == bank_addr && r_p_row[i] == row_addr) begin
        w_row_hit = 1'b1;
        w_row_idx = PW'(i);
      end
      if (r_p_valid[i] && r_p_bank[i] == bank_addr && r_p_col[i] == col_addr) begin
        w_col_hit = 1'b1;
        w_col_idx = PW'(i);
      end
    end
  end

`ifdef BIRA_DUP_FILTER_EN
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < PCAM; i++)
      if (r_p_valid[i] && r_p_bank[i] == bank_addr && r_p_row[i] == row_addr && r_p_col[i] == col_addr)
        w_dup = 1'b1;
    for (int j = 0; j < NPCAM; j++)
      if (r_n_valid[j] && r_n_bank[j] == bank_addr && r_n_row[j] == row_addr && r_n_col[j] == col_addr)
        w_dup = 1'b1;
  end
`else
  assign w_dup = 1'b0;
`endif

  // Saturating sharing counters; must flags compare the post-increment count plus one.
  assign w_rcnt_nxt = (r_p_rcnt[w_row_idx] == CW'(NPCAM)) ? r_p_rcnt[w_row_idx] : r_p_rcnt[w_row_idx] + CW'(1);
  assign w_ccnt_nxt = (r_p_ccnt[w_col_idx] == CW'(NPCAM)) ? r_p_ccnt[w_col_idx] : r_p_ccnt[w_col_idx] + CW'(1);
  assign w_set_mr   = ({1'b0, w_rcnt_nxt} + (CW+1)'(1)) > (CW+1)'(C_SPARE);
  assign w_set_mc   = ({1'b0, w_ccnt_nxt} + (CW+1)'(1)) > (CW+1)'(R_SPARE);

  assign w_accept   = fault_valid && (r_state == S_COLLECT) && !w_dup;
  assign w_is_pivot = !w_row_hit && !w_col_hit;
  assign w_overflow = w_accept && (w_is_pivot ? (r_pivot_cnt == (PW+1)'(PCAM))
                                              : (r_npivot_cnt == CW'(NPCAM)));
  assign w_wr_p     = w_accept && w_is_pivot && !w_overflow;
  assign w_wr_n     = w_accept && !w_is_pivot && !w_overflow;
  assign w_clear    = rst || ((r_state == S_DONE) && ana_ack);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (test_end) w_state_nxt = S_DONE;
                 else if (w_overflow) w_state_nxt = S_TERM;
                 else w_state_nxt = S_COLLECT;
      S_TERM:    if (test_end) w_state_nxt = S_DONE;
                 else w_state_nxt = S_TERM;
      S_DONE:    if (ana_ack) w_state_nxt = S_COLLECT;
                 else w_state_nxt = S_DONE;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Output decode and entry packing.
  always_comb begin
    fault_ready = (r_state == S_COLLECT);
    cam_done    = (r_state == S_DONE);
    pivot_entries  = '0;
    npivot_entries = '0;
    for (int i = 0; i < PCAM; i++)
      pivot_entries[i*(E+2) +: (E+2)] = {r_p_valid[i], r_p_bank[i], r_p_row[i], r_p_col[i], r_p_mr[i], r_p_mc[i]};
    for (int j = 0; j < NPCAM; j++)
      npivot_entries[j*(E+PW) +: (E+PW)] = {r_n_valid[j], r_n_bank[j], r_n_row[j], r_n_col[j], r_n_ptr[j]};
  end

  assign pivot_cnt  = r_pivot_cnt;
  assign npivot_cnt = r_npivot_cnt;
  assign early_term = r_early_term;

  // CAM storage, counts and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < PCAM; i++) begin
        r_p_valid[i] <= 1'b0;
        r_p_bank[i]  <= '0;
        r_p_row[i]   <= '0;
        r_p_col[i]   <= '0;
        r_p_mr[i]    <= 1'b0;
        r_p_mc[i]    <= 1'b0;
        r_p_rcnt[i]  <= '0;
        r_p_ccnt[i]  <= '0;
      end
      for (int j = 0; j < NPCAM; j++) begin
        r_n_valid[j] <= 1'b0;
        r_n_bank[j]  <= '0;
        r_n_row[j]   <= '0;
        r_n_col[j]   <= '0;
        r_n_ptr[j]   <= '0;
      end
      r_pivot_cnt  <= '0;
      r_npivot_cnt <= '0;
      r_early_term <= 1'b0;
    end else begin
      if (w_overflow) r_early_term <= 1'b1;
      if (w_wr_p)     r_pivot_cnt  <= r_pivot_cnt + (PW+1)'(1);
      if (w_wr_n)     r_npivot_cnt <= r_npivot_cnt + CW'(1);
      for (int i = 0; i < PCAM; i++) begin
        if (w_wr_p && r_pivot_cnt == (PW+1)'(i)) begin
          r_p_valid[i] <= 1'b1;
          r_p_bank[i]  <= bank_addr;
          r_p_row[i]   <= row_addr;
          r_p_col[i]   <= col_addr;
        end
        if (w_wr_n && w_row_hit && w_row_idx == PW'(i)) begin
          r_p_rcnt[i] <= w_rcnt_nxt;
          if (w_set_mr) r_p_mr[i] <= 1'b1;
        end
        if (w_wr_n && w_col_hit && w_col_idx == PW'(i)) begin
          r_p_ccnt[i] <= w_ccnt_nxt;
          if (w_set_mc) r_p_mc[i] <= 1'b1;
        end
      end
      for (int j = 0; j < NPCAM; j++) begin
        if (w_wr_n && r_npivot_cnt == CW'(j)) begin
          r_n_valid[j] <= 1'b1;
          r_n_bank[j]  <= bank_addr;
          r_n_row[j]   <= row_addr;
          r_n_col[j]   <= col_addr;
          r_n_ptr[j]   <= w_row_hit ? w_row_idx : w_col_idx;
        end
      end
    end
  end

endmodule

// File: doc/bira_fault_cam.md
# bira_fault_cam

Parametrised fault-collection CAM for the BIRA path, the next generation of the fixed 8-pivot/30-non-pivot storage. It accepts fault addresses from BIST one per cycle, classifies each as pivot or non-pivot, tracks per-pivot row/column sharing counts to raise must-repair flags, and stops collection with `early_term` when the pivot or non-pivot CAM would overflow. After `test_end` it freezes its contents for the analyzer and clears on the analyzer's acknowledge.

## Interface
- `ROW_W`, 10, fault row address width
- `COL_W`, 10, fault column address width
- `BANK_W`, 2, bank address width
- `PCAM`, 8, pivot CAM depth; must equal `R_SPARE + C_SPARE`
- `NPCAM`, 30, non-pivot CAM depth
- `R_SPARE`, 4, spare rows
- `C_SPARE`, 4, spare columns
- Derived: `PW = clog2(PCAM)`, `CW = clog2(NPCAM+1)`, `E = 1+BANK_W+ROW_W+COL_W`

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `fault_valid` in 1: fault address presented
- `fault_ready` out 1: CAM can accept a fault
- `row_addr` in ROW_W: faulty row
- `col_addr` in COL_W: faulty column
- `bank_addr` in BANK_W: faulty bank
- `test_end` in 1: BIST finished
- `ana_ack` in 1: analyzer done with frozen contents
- `pivot_entries` out PCAM*(E+2): per entry `{valid, bank, row, col, must_row, must_col}`, entry 0 in LSBs
- `npivot_entries` out NPCAM*(E+PW): per entry `{valid, bank, row, col, ptr}`
- `pivot_cnt` out PW+1: stored pivots
- `npivot_cnt` out CW: stored non-pivots
- `early_term` out 1: overflow, sticky until reset or ack
- `cam_done` out 1: contents frozen for analysis

## Operation
- States: COLLECT (reset state), TERM, DONE.
- COLLECT: `fault_ready=1`. On `fault_valid`, compare against all valid pivots of the same bank:
  - Row match: pivot row equals `row_addr`. Column match: pivot col equals `col_addr`. Pivots have distinct rows and columns per bank, so at most one of each matches.
  - No row match and no column match gives a new pivot, written to index `pivot_cnt`. If `pivot_cnt == PCAM`, nothing is written; go to TERM.
  - Otherwise it is a non-pivot, written to index `npivot_cnt`. `ptr` is the row-match pivot if present, else the column-match pivot. The row-match pivot's row counter increments. The column-match pivot's column counter increments. If `npivot_cnt == NPCAM`, nothing is written, counters are unchanged, and the block goes to TERM.
- Must-repair: `must_row` is set when the row counter + 1 > `C_SPARE`; `must_col` is set when the column counter + 1 > `R_SPARE`. Both are sticky and compared against the post-increment value.
- Counters are CW bits and saturate at NPCAM.
- `test_end` in COLLECT goes to DONE. If `fault_valid` is asserted in the same cycle, that fault is processed first.
- TERM: `fault_ready=0`, `early_term=1`. `test_end` goes to DONE with `early_term` held.
- DONE: `fault_ready=0`, `cam_done=1`, contents held. `ana_ack` clears all entries, counters, counts and `early_term`, then returns to COLLECT.
- `ana_ack` outside DONE is ignored. `fault_valid` while not ready is dropped.

## Timing
- Reset values: all entries invalid or zero, `pivot_cnt=0`, `npivot_cnt=0`, `early_term=0`, `cam_done=0`, `fault_ready=1`, state COLLECT.
- `rst` mid-operation clears everything on that edge regardless of state.
- Single-cycle insertion: a fault accepted at edge N is visible in the entries, counts and must flags after edge N. A fault at edge N+1 compares against it, so back-to-back faults need no forwarding.
- `early_term` and TERM are asserted after the overflowing fault's edge. `fault_ready` falls in the same cycle.
- `cam_done` rises the cycle after the `test_end` edge and falls the cycle after the `ana_ack` edge.

## Configuration
- `BIRA_DUP_FILTER_EN` defined: a fault whose bank, row and col exactly equal a stored pivot or non-pivot is discarded. No write, no counter change, no overflow check.
- Not defined: a duplicate is processed normally. A duplicate of a pivot becomes a non-pivot that matches both row and column, so `ptr` points to that pivot and both of its counters increment.

## Test plan
- Reset, then fault (b0,r5,c7), then (b0,r5,c9) gives pivot0 = {1,0,5,7}, nonpivot0 `ptr=0`, pivot0 row counter = 1, `pivot_cnt=1`, `npivot_cnt=1`.
- Five faults on (b1,r3) with columns 1..5 give pivot at c1 plus 4 non-pivots. `must_row` rises after the 5th fault (count 4, +1 = 5 > 4). `must_col` stays 0.
- Nine faults with distinct rows and columns in bank 0: 8 pivots stored, then `early_term=1` and `fault_ready=0` after the 9th. `pivot_cnt` stays 8.
- (b0,r1,c1) and (b2,r1,c1) give two pivots, because a bank mismatch means no match.
- Send (b0,r2,c2) twice. With `BIRA_DUP_FILTER_EN`: `npivot_cnt=0`. Without it: `npivot_cnt=1`, both counters of pivot0 = 1.
- `test_end` with a concurrent fault: the fault is stored, `cam_done=1` the next cycle, later faults are ignored. `ana_ack` clears everything and returns `fault_ready=1`. `rst` asserted in DONE clears the block the same way.
